// File: rtl/icache_axi_pkg.sv
// Shared AXI constants and refill FSM encoding for the icache refill master.
package icache_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAr   = 2'd1,
        StR    = 2'd2,
        StResp = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill_linebuf.sv
// Line buffer: LINE_BEATS x 64-bit registers, one beat written per cycle, flat line out.
module icache_refill_linebuf #(
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned IdxW       = $clog2(LINE_BEATS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [IdxW-1:0]            idx_i,
    input  logic [63:0]                data_i,
    output logic [LINE_BEATS*64-1:0]   line_o
);

    logic [LINE_BEATS-1:0][63:0] buf_q;

    // Beat write into the indexed slot; unwritten slots keep their old contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
        end else if (we_i) begin
            buf_q[idx_i] <= data_i;
        end
    end

    assign line_o = buf_q;

endmodule

// File: rtl/icache_axi_refill.sv
// AXI4 read master refilling one icache line per request with a single INCR burst.
module icache_axi_refill
    import icache_axi_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4,
    parameter logic [3:0]  AXI_ID     = 4'h1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic                      flush,
    output logic                      resp_valid,
    output logic [LINE_BEATS*64-1:0]  resp_data,
    output logic                      resp_err,
    output logic [31:0]               m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic [3:0]                m_arid,
    output logic [3:0]                m_arcache,
    output logic                      m_arlock,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [63:0]               m_rdata,
    input  logic [3:0]                m_rid,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int unsigned CntW     = $clog2(LINE_BEATS);
    localparam logic [CntW-1:0] LastIdx = CntW'(LINE_BEATS - 1);
    localparam logic [31:0] OffMask  = 32'(LINE_BEATS * 8 - 1);

    refill_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;

    logic in_ar, in_r, beat_we, last_slot, beat_end;

    assign in_ar     = (state_q == StAr);
    assign in_r      = (state_q == StR);
    assign beat_we   = in_r && m_rvalid;
    assign last_slot = (cnt_q == LastIdx);
    assign beat_end  = m_rlast || last_slot;

    // Next-state: FSM, beat counter, sticky error and drop flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        drop_d  = drop_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr & ~OffMask;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (flush)     drop_d  = 1'b1;
                if (m_arready) state_d = StR;
            end
            StR: begin
                if (flush) drop_d = 1'b1;
                if (m_rvalid) begin
                    // rlast must coincide exactly with the last slot.
                    if (m_rresp != AXI_RESP_OKAY || m_rid != AXI_ID || (m_rlast != last_slot)) begin
                        err_d = 1'b1;
                    end
                    if (beat_end) begin
                        state_d = StResp;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StResp: begin
                drop_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    icache_refill_linebuf #(
        .LINE_BEATS (LINE_BEATS)
    ) u_linebuf (
        .clk_i  (aclk),
        .rst_i  (areset),
        .we_i   (beat_we),
        .idx_i  (cnt_q),
        .data_i (m_rdata),
        .line_o (resp_data)
    );

    // AR payload is only driven while in AR so every payload output reads 0 otherwise.
    assign m_arvalid = in_ar;
    assign m_araddr  = in_ar ? addr_q : 32'h0;
    assign m_arlen   = in_ar ? 8'(LINE_BEATS - 1) : 8'h0;
    assign m_arsize  = in_ar ? AXI_SIZE_8B : 3'b000;
    assign m_arburst = in_ar ? AXI_BURST_INCR : 2'b00;
    assign m_arid    = in_ar ? AXI_ID : 4'h0;
    assign m_arcache = 4'h0;
    assign m_arlock  = 1'b0;
    assign m_arprot  = 3'b000;

    assign m_rready   = in_r;
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp) && !drop_q;
    assign resp_err   = (state_q == StResp) && !drop_q && err_q;

endmodule
